// File: rtl/legv8_branch_predictor.sv
// Dynamic branch predictor for the LEGv8 fetch stage: direct-mapped BTB plus a
// PHT of saturating counters, indexed bimodally (MODE 0) or via gshare (MODE 1).
module legv8_branch_predictor #(
  parameter int PC_WIDTH = 64,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int MODE     = 0,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  output logic [IDX_W-1:0]    lookup_pht_idx,
  input  logic                update_valid,
  input  logic [PC_WIDTH-1:0] update_pc,
  input  logic                update_taken,
  input  logic [PC_WIDTH-1:0] update_target,
  input  logic [IDX_W-1:0]    update_pht_idx,
  input  logic                update_mispredict,
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_mispredicts
);

  localparam int TAG_W = PC_WIDTH - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4);

  function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] c,
                                                   input logic taken);
    if (taken) return (c == CTR_MAX) ? c : c + 1'b1;
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [31:0] stat_inc(input logic [31:0] s);
    return (s == 32'hFFFF_FFFF) ? s : s + 32'd1;
  endfunction

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_d    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];
  logic [PC_WIDTH-1:0] target_d [ENTRIES];
  logic [CTR_BITS-1:0] pht_q    [ENTRIES];
  logic [CTR_BITS-1:0] pht_d    [ENTRIES];
  logic [IDX_W-1:0]    ghr_q, ghr_d;
  logic [31:0]         stat_upd_q, stat_upd_d;
  logic [31:0]         stat_mis_q, stat_mis_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             unused_pc_lsbs;

  assign lk_idx         = lookup_pc[IDX_W+1:2];
  assign lk_tag         = lookup_pc[PC_WIDTH-1:IDX_W+2];
  assign up_idx         = update_pc[IDX_W+1:2];
  assign up_tag         = update_pc[PC_WIDTH-1:IDX_W+2];
  assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  // Lookup reads only registered state, so a same-cycle update is not bypassed.
  always_comb begin
    lookup_pht_idx = (MODE == 1) ? (lk_idx ^ ghr_q) : lk_idx;
    pred_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken     = pred_hit && pht_q[lookup_pht_idx][CTR_BITS-1];
    pred_target    = pred_taken ? target_q[lk_idx] : lookup_pc + PC_STEP;
  end

  assign stat_updates     = stat_upd_q;
  assign stat_mispredicts = stat_mis_q;

  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    target_d   = target_q;
    pht_d      = pht_q;
    ghr_d      = ghr_q;
    stat_upd_d = stat_upd_q;
    stat_mis_d = stat_mis_q;
    if (update_valid) begin
      pht_d[update_pht_idx] = ctr_next(pht_q[update_pht_idx], update_taken);
      // A taken branch either refreshes a hit or (re)allocates over an alias;
      // both cases write the same valid/tag/target fields.
      if (update_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = update_target;
      end
      ghr_d      = (MODE == 1) ? {ghr_q[IDX_W-2:0], update_taken} : '0;
      stat_upd_d = stat_inc(stat_upd_q);
      if (update_mispredict) stat_mis_d = stat_inc(stat_mis_q);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      valid_q    <= '0;
      ghr_q      <= '0;
      stat_upd_q <= '0;
      stat_mis_q <= '0;
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= CTR_INIT;
    end else begin
      valid_q    <= valid_d;
      ghr_q      <= ghr_d;
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
      pht_q      <= pht_d;
    end
  end

  // Tag and target are qualified by valid_q, so they carry no reset.
  always_ff @(posedge CLOCK) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: doc/legv8_branch_predictor.md
Name: legv8_branch_predictor

Overview:
- Parametrised dynamic branch predictor for the LEGv8 5-stage pipeline. It replaces the current static "predict not-taken, resolve in MEM" scheme.
- Sits beside the fetch-stage PC adder. Fetch reads a combinational prediction (BTB hit, direction, target) from flop-based tables; the resolving stage writes branch outcomes back.
- Supports bimodal or gshare direction prediction, and keeps saturating update/mispredict statistics.

Parameters:
- PC_WIDTH, 64, width of PC and target buses.
- ENTRIES, 16, BTB and PHT depth; power of 2, minimum 4. IDX_W = log2(ENTRIES).
- CTR_BITS, 2, PHT saturating counter width, 1 to 4.
- MODE, 0, 0 = bimodal (PHT index = PC index), 1 = gshare (PHT index = PC index XOR GHR, GHR is IDX_W bits).

Ports:
- CLOCK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset
- lookup_pc  in  PC_WIDTH  fetch PC
- pred_hit  out  1  valid BTB entry with matching tag
- pred_taken  out  1  hit AND PHT counter MSB set
- pred_target  out  PC_WIDTH  BTB target if pred_taken, else lookup_pc+4
- lookup_pht_idx  out  IDX_W  PHT index used for this lookup; pipeline carries it to resolution
- update_valid  in  1  resolved branch this cycle
- update_pc  in  PC_WIDTH  PC of resolved branch
- update_taken  in  1  actual direction
- update_target  in  PC_WIDTH  actual taken target
- update_pht_idx  in  IDX_W  lookup_pht_idx carried with the branch
- update_mispredict  in  1  pipeline flushed for this branch; used only for statistics
- stat_updates  out  32  count of update_valid cycles, saturating
- stat_mispredicts  out  32  count of update_valid AND update_mispredict, saturating

Behaviour:
- Address fields:
  - pc_idx = pc[IDX_W+1:2].
  - tag = pc[PC_WIDTH-1:IDX_W+2].
  - pc[1:0] is ignored.
- Lookup is purely combinational from registered state: zero-cycle latency, no valid/ready handshake.
- BTB entry fields: valid, tag, target. Index = pc_idx of lookup_pc / update_pc.
- PHT index:
  - MODE 0: lookup_pht_idx = pc_idx.
  - MODE 1: lookup_pht_idx = pc_idx XOR GHR.
  - Updates always write PHT[update_pht_idx] and never recompute the index.
- Update on rising CLOCK when update_valid = 1:
  - PHT: taken saturating-increments the counter (max 2^CTR_BITS-1); not-taken saturating-decrements it (min 0).
  - BTB hit (valid and tag match) with taken: target <= update_target.
  - BTB miss with taken: allocate the entry; valid <= 1, tag and target written. Any aliasing entry is overwritten.
  - Not-taken never allocates and never invalidates.
  - MODE 1: GHR <= {GHR[IDX_W-2:0], update_taken}. MODE 0: GHR is unused and held at 0.
  - stat_updates += 1 (saturating at 0xFFFFFFFF). stat_mispredicts += 1 if update_mispredict (saturating).
- update_valid = 0: no state changes; update_mispredict is ignored.
- Same-cycle lookup and update to the same entry: lookup outputs reflect pre-edge state; the new state is visible from the next cycle. No bypass.
- pred_target when not taken: lookup_pc + 4, modulo 2^PC_WIDTH. Wraps at the top of the address space.
- Reset (RESET = 0), asynchronous and effective immediately without a clock edge:
  - All BTB valid bits <= 0.
  - PHT counters <= weakly not-taken, i.e. 2^(CTR_BITS-1) - 1 (CTR_BITS = 1 gives 0).
  - GHR <= 0; both statistics counters <= 0.
- Outputs during and after reset: pred_hit = 0, pred_taken = 0, pred_target = lookup_pc+4, stats = 0.
- Reset deassertion is synchronous to CLOCK; the first update is accepted on the first rising edge with RESET = 1.
- Reset mid-operation discards all learned state; an in-flight update on the same edge is lost.

Test Plan:
All cases use ENTRIES=16 and CTR_BITS=2. pc 0x48 gives idx 2, tag 1; pc 0x88 gives idx 2, tag 2.
1. Post-reset: lookup_pc 0x48 -> pred_hit 0, pred_taken 0, pred_target 0x4C, lookup_pht_idx 2, stats 0.
2. MODE 0, one update (0x48, taken, target 0x100), then lookup 0x48 -> hit 1, counter 2'b10, pred_taken 1, pred_target 0x100, stat_updates 1.
3. Direction saturation:
   - Two not-taken updates on 0x48 -> counter 01 then 00; pred_taken 0, hit 1, target 0x4C.
   - A third not-taken update -> counter stays 00.
   - Four taken updates -> counter 11; a fifth stays 11.
4. Aliasing: 0x48 allocated; lookup 0x88 -> hit 0. Taken update (0x88, target 0x200) -> lookup 0x88 hits with target 0x200; lookup 0x48 -> hit 0.
5. Same-cycle update (0x48, taken, 0x300) and lookup 0x48 with entry target 0x100 -> that cycle shows 0x100, next cycle 0x300. With update_mispredict = 1, stat_mispredicts goes 0 -> 1.
6. MODE 1 and async reset:
   - Updates taken, taken, not-taken -> GHR 0001, 0011, 0110. lookup 0x48 -> lookup_pht_idx 4.
   - Drive RESET low mid-cycle -> pred_hit drops to 0 and stats clear before the next edge; GHR = 0 after release.
